// File: rtl/flag_unit_nzcv.sv
// NZCV status-flag unit for the ARMv4 datapath.
// Derives N/Z/C/V from the ALU operands, result and carries. The flags pass
// through a pending stage and then an architectural stage. The unit also
// evaluates the ARM condition field against the effective flags and counts
// committed overflow events in a saturating counter.
module flag_unit_nzcv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int FWD   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             alu_cout,
    input  logic             shift_cout,
    input  logic [1:0]       alu_op,
    input  logic             flag_we,
    input  logic             stall,
    input  logic             flush,
    input  logic             msr_we,
    input  logic [3:0]       msr_flags,
    input  logic [3:0]       cond,
    input  logic             cnt_clr,
    output logic             cond_pass,
    output logic [3:0]       flags,
    output logic [3:0]       next_flags,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOGIC = 2'b10;
    localparam logic [1:0] OP_RSB   = 2'b11;

    // Flag vector bit positions: {N,Z,C,V}
    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    // Signed overflow from the operand and result sign bits. Logical ops
    // leave V untouched, so they return the caller's current V.
    function automatic logic calc_ovf(
        input logic [1:0] op,
        input logic       sa,
        input logic       sb,
        input logic       sr,
        input logic       v_keep
    );
        logic v;
        case (op)
            OP_ADD:   v = (sa == sb) & (sr != sa);
            OP_SUB:   v = (sa != sb) & (sr != sa);
            OP_RSB:   v = (sa != sb) & (sr != sb);
            OP_LOGIC: v = v_keep;
            default:  v = v_keep;
        endcase
        return v;
    endfunction

    // ARM condition-code decode against an {N,Z,C,V} vector.
    function automatic logic cond_eval(
        input logic [3:0] c,
        input logic [3:0] f
    );
        logic n, z, cy, v, p;
        n  = f[F_N];
        z  = f[F_Z];
        cy = f[F_C];
        v  = f[F_V];
        case (c)
            4'b0000: p = z;                  // EQ
            4'b0001: p = ~z;                 // NE
            4'b0010: p = cy;                 // CS
            4'b0011: p = ~cy;                // CC
            4'b0100: p = n;                  // MI
            4'b0101: p = ~n;                 // PL
            4'b0110: p = v;                  // VS
            4'b0111: p = ~v;                 // VC
            4'b1000: p = cy & ~z;            // HI
            4'b1001: p = ~cy | z;            // LS
            4'b1010: p = (n == v);           // GE
            4'b1011: p = (n != v);           // LT
            4'b1100: p = ~z & (n == v);      // GT
            4'b1101: p = z | (n != v);       // LE
            4'b1110: p = 1'b1;               // AL
            4'b1111: p = 1'b0;               // NV
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    logic             pend_valid_q, pend_valid_d;
    logic [3:0]       pend_flags_q, pend_flags_d;
    logic [3:0]       flags_q,      flags_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic [3:0]       eff_flags_s;
    logic [3:0]       next_flags_s;
    logic             commit_s;
    logic             cnt_sat_s;

    // Effective flags seen by condition evaluation and by logical-op V.
    always_comb begin
        eff_flags_s = flags_q;
        if ((FWD != 0) && pend_valid_q) begin
            eff_flags_s = pend_flags_q;
        end else begin
            eff_flags_s = flags_q;
        end
    end

    // Flags this instruction would produce if its S-bit is set.
    always_comb begin
        next_flags_s      = 4'b0000;
        next_flags_s[F_N] = result[WIDTH-1];
        next_flags_s[F_Z] = (result == {WIDTH{1'b0}});
        if (alu_op == OP_LOGIC) begin
            next_flags_s[F_C] = shift_cout;
        end else begin
            next_flags_s[F_C] = alu_cout;
        end
        next_flags_s[F_V] = calc_ovf(alu_op, a[WIDTH-1], b[WIDTH-1],
                                     result[WIDTH-1], eff_flags_s[F_V]);
    end

    // A commit happens only when the pipe advances and MSR is not overriding it.
    always_comb begin
        commit_s  = 1'b0;
        cnt_sat_s = &cnt_q;
        if (!msr_we && !stall && pend_valid_q) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Pending stage next state: MSR discards it, stall holds it, flush kills it.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_flags_d = pend_flags_q;
        if (msr_we) begin
            pend_valid_d = 1'b0;
        end else if (stall) begin
            pend_valid_d = pend_valid_q;
        end else begin
            pend_valid_d = flag_we & ~flush;
            if (flag_we) begin
                pend_flags_d = next_flags_s;
            end else begin
                pend_flags_d = pend_flags_q;
            end
        end
    end

    // Architectural flags next state: MSR write wins over a commit.
    always_comb begin
        flags_d = flags_q;
        if (msr_we) begin
            flags_d = msr_flags;
        end else if (commit_s) begin
            flags_d = pend_flags_q;
        end else begin
            flags_d = flags_q;
        end
    end

    // Overflow-event counter: clear beats increment, increment saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (commit_s && pend_flags_q[F_V] && !cnt_sat_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pending stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_flags_q <= 4'b0000;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_flags_q <= pend_flags_d;
        end
    end

    // Architectural flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Overflow-event counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign next_flags = next_flags_s;
    assign flags      = flags_q;
    assign ovf_count  = cnt_q;
    assign cond_pass  = cond_eval(cond, eff_flags_s);

endmodule

// File: tb/tb_flag_unit_nzcv.sv
// Self-checking bench for flag_unit_nzcv: a forwarding instance with a 2-bit
// counter and a non-forwarding instance with a 16-bit counter share stimulus
// and are compared against an arithmetic reference model every cycle.
module tb_flag_unit_nzcv;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOGIC = 2'b10, RSB = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b, result;
    logic        alu_cout, shift_cout;
    logic [1:0]  alu_op;
    logic        flag_we, stall, flush, msr_we, cnt_clr;
    logic [3:0]  msr_flags, cond;

    logic        cp1, cp0;
    logic [3:0]  fl1, fl0, nf1, nf0;
    logic [1:0]  oc1;
    logic [15:0] oc0;

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = forwarding/CNT_W=2, 1 = no forwarding/CNT_W=16
    int         m_pv [2];
    logic [3:0] m_pf [2];
    logic [3:0] m_fl [2];
    int         m_cnt[2];
    int         CMAX [2] = '{3, 65535};
    int         FWDP [2] = '{1, 0};

    flag_unit_nzcv #(.WIDTH(32), .CNT_W(2), .FWD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .result(result),
        .alu_cout(alu_cout), .shift_cout(shift_cout), .alu_op(alu_op),
        .flag_we(flag_we), .stall(stall), .flush(flush), .msr_we(msr_we),
        .msr_flags(msr_flags), .cond(cond), .cnt_clr(cnt_clr),
        .cond_pass(cp1), .flags(fl1), .next_flags(nf1), .ovf_count(oc1)
    );

    flag_unit_nzcv #(.WIDTH(32), .CNT_W(16), .FWD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .result(result),
        .alu_cout(alu_cout), .shift_cout(shift_cout), .alu_op(alu_op),
        .flag_we(flag_we), .stall(stall), .flush(flush), .msr_we(msr_we),
        .msr_flags(msr_flags), .cond(cond), .cnt_clr(cnt_clr),
        .cond_pass(cp0), .flags(fl0), .next_flags(nf0), .ovf_count(oc0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] eff(input int i);
        return (FWDP[i] != 0 && m_pv[i] != 0) ? m_pf[i] : m_fl[i];
    endfunction

    // Flags from true signed arithmetic rather than sign-bit rules.
    function automatic logic [3:0] ref_next(input int i);
        longint sa, sb, x;
        logic n, z, c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = result[31];
        z  = (result == 32'd0);
        c  = alu_cout;
        x  = 64'sd0;
        case (alu_op)
            ADD:     x = sa + sb;
            SUB:     x = sa - sb;
            RSB:     x = sb - sa;
            default: x = 64'sd0;
        endcase
        if (alu_op == LOGIC) begin
            c = shift_cout;
            v = eff(i)[0];
        end else begin
            v = (x > 64'sd2147483647) || (x < -64'sd2147483648);
        end
        return {n, z, c, v};
    endfunction

    // Conditions come in predicate/inverse pairs; 1110 is always, 1111 never.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pv[i] = 0; m_pf[i] = 4'b0000; m_fl[i] = 4'b0000; m_cnt[i] = 0;
        end
    endtask

    // Compare every output of both instances at the falling edge.
    task automatic cyc();
        @(negedge clk);
        chk("nf_fwd",   {28'd0, nf1}, {28'd0, ref_next(0)});
        chk("nf_nofwd", {28'd0, nf0}, {28'd0, ref_next(1)});
        chk("cp_fwd",   {31'd0, cp1}, {31'd0, ref_cond(cond, eff(0))});
        chk("cp_nofwd", {31'd0, cp0}, {31'd0, ref_cond(cond, eff(1))});
        chk("fl_fwd",   {28'd0, fl1}, {28'd0, m_fl[0]});
        chk("fl_nofwd", {28'd0, fl0}, {28'd0, m_fl[1]});
        chk("cnt_fwd",  {30'd0, oc1}, m_cnt[0]);
        chk("cnt_nofwd",{16'd0, oc0}, m_cnt[1]);
    endtask

    // Advance the reference model across the rising edge.
    task automatic tick();
        logic [3:0] nf;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                nf = ref_next(i);
                if (msr_we) begin
                    m_fl[i] = msr_flags;
                    m_pv[i] = 0;
                end else if (!stall) begin
                    if (m_pv[i] != 0) begin
                        m_fl[i] = m_pf[i];
                        if (m_pf[i][0] && m_cnt[i] < CMAX[i]) m_cnt[i]++;
                    end
                    m_pv[i] = (flag_we && !flush) ? 1 : 0;
                    if (flag_we && !flush) m_pf[i] = nf;
                end
                if (cnt_clr) m_cnt[i] = 0;
            end
        end
        #1;
    endtask

    task automatic set_alu(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        alu_op = op; a = x; b = y;
        shift_cout = 1'($urandom_range(0, 1));
        case (op)
            ADD:     s = {1'b0, x} + {1'b0, y};
            SUB:     s = {1'b0, x} + {1'b0, ~y} + 33'd1;
            RSB:     s = {1'b0, y} + {1'b0, ~x} + 33'd1;
            default: s = {1'($urandom_range(0, 1)), x & y};
        endcase
        result = s[31:0]; alu_cout = s[32];
    endtask

    initial begin
        logic [31:0] x, y;
        int r;
        rst_n = 1'b0; flag_we = 1'b0; stall = 1'b0; flush = 1'b0; msr_we = 1'b0;
        cnt_clr = 1'b0; msr_flags = 4'b0000; cond = 4'b1110;
        set_alu(ADD, 32'd0, 32'd0);
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        cyc();
        chk("reset_flags", {28'd0, fl1}, 32'h0);
        chk("reset_cnt",   {30'd0, oc1}, 32'h0);
        tick();

        // ADD overflow: N and V set, visible on flags two cycles later
        set_alu(ADD, 32'h7FFFFFFF, 32'd1); flag_we = 1'b1;
        cyc(); chk("add_ovf_next", {28'd0, nf1}, 32'h9); tick();
        flag_we = 1'b0;
        cyc(); chk("add_ovf_t1", {28'd0, fl1}, 32'h0); tick();
        cyc(); chk("add_ovf_t2", {28'd0, fl1}, 32'h9);
        chk("add_ovf_cnt", {30'd0, oc1}, 32'd1); tick();

        // SUB of equal operands sets Z and C; forwarding shows it one cycle early
        set_alu(SUB, 32'd5, 32'd5); flag_we = 1'b1; cond = 4'b0000;
        cyc(); tick();
        flag_we = 1'b0;
        cyc();
        chk("eq_fwd_t1",   {31'd0, cp1}, 32'd1);
        chk("eq_nofwd_t1", {31'd0, cp0}, 32'd0);
        cond = 4'b1100; #1;
        chk("gt_fwd_t1",   {31'd0, cp1}, 32'd0);
        tick();
        cond = 4'b0000;
        cyc();
        chk("eq_nofwd_t2", {31'd0, cp0}, 32'd1);
        chk("sub_flags",   {28'd0, fl1}, 32'h6);
        tick();

        // Flushed update never commits
        set_alu(ADD, 32'h7FFFFFFF, 32'd1); flag_we = 1'b1; flush = 1'b1;
        cyc(); tick();
        flag_we = 1'b0; flush = 1'b0;
        cyc(); tick();
        cyc(); chk("flush_flags", {28'd0, fl1}, 32'h6);
        chk("flush_cnt", {30'd0, oc1}, 32'd1); tick();

        // Stall holds pending and architectural stages
        set_alu(ADD, 32'd1, 32'd1); flag_we = 1'b1;
        cyc(); tick();
        flag_we = 1'b0; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(); chk("stall_hold", {28'd0, fl1}, 32'h6); tick();
        end
        stall = 1'b0;
        cyc(); chk("stall_release", {28'd0, fl1}, 32'h6); tick();
        cyc(); chk("stall_commit", {28'd0, fl1}, 32'h0); tick();

        // MSR write overrides a same-cycle commit and does not count
        set_alu(ADD, 32'h7FFFFFFF, 32'd1); flag_we = 1'b1;
        cyc(); tick();
        flag_we = 1'b0; msr_we = 1'b1; msr_flags = 4'b0011;
        cyc(); tick();
        msr_we = 1'b0;
        cyc(); chk("msr_flags", {28'd0, fl1}, 32'h3);
        chk("msr_cnt", {30'd0, oc1}, 32'd1); tick();
        cyc(); chk("msr_no_late", {28'd0, fl1}, 32'h3); tick();

        // Five committed V updates saturate a 2-bit counter
        set_alu(ADD, 32'h7FFFFFFF, 32'd1); flag_we = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(); tick();
        end
        flag_we = 1'b0;
        cyc(); tick();
        cyc(); chk("sat_cnt", {30'd0, oc1}, 32'd3);
        chk("sat_cnt_wide", {16'd0, oc0}, 32'd6); tick();

        // Clear wins over a same-cycle increment
        flag_we = 1'b1;
        cyc(); tick();
        flag_we = 1'b0; cnt_clr = 1'b1;
        cyc(); tick();
        cnt_clr = 1'b0;
        cyc(); chk("clr_over_inc", {30'd0, oc1}, 32'd0); tick();

        // Asynchronous reset mid-stream with an update pending
        flag_we = 1'b1;
        cyc(); tick();
        cyc(); tick();
        flag_we = 1'b0; rst_n = 1'b0; #1;
        chk("async_rst_flags", {28'd0, fl1}, 32'h0);
        chk("async_rst_cnt",   {30'd0, oc1}, 32'h0);
        chk("async_rst_cnt0",  {16'd0, oc0}, 32'h0);
        model_reset();
        cyc(); tick();
        rst_n = 1'b1;
        cyc(); chk("post_rst_t1", {28'd0, fl1}, 32'h0); tick();
        cyc(); chk("post_rst_t2", {28'd0, fl1}, 32'h0); tick();

        // Randomized traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            x = $urandom; y = $urandom;
            r = $urandom_range(0, 5);
            if (r == 0) y = x;
            else if (r == 1) x = 32'h7FFFFFFF ^ 32'($urandom_range(0, 3));
            else if (r == 2) x = 32'h80000000 | 32'($urandom_range(0, 3));
            set_alu(2'($urandom_range(0, 3)), x, y);
            flag_we   = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 9) == 0);
            stall     = ($urandom_range(0, 19) < 3);
            msr_we    = ($urandom_range(0, 19) == 0);
            cnt_clr   = ($urandom_range(0, 29) == 0);
            msr_flags = 4'($urandom_range(0, 15));
            cond      = 4'($urandom_range(0, 15));
            cyc(); tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
